proj_minhash_accum: RTL and testbench

//  Downstream consumer of proj_counter in the MinHash datapath. Samples the

---
 rtl/proj_minhash_accum.sv | 103 ++++++++++
 tb/tb_proj_minhash_accum.sv | 133 +++++++++++++
 2 files changed

// File: rtl/proj_minhash_accum.sv
// proj_minhash_accum: tracks min of h(i)=(A*i+B) mod 2^HASH_W over set feature-map bits, publishes one signature per pass.
// Optional argmin output sig_idx enabled by defining PROJ_MINHASH_ARGMIN_EN.
module proj_minhash_accum #(
    parameter int FM_BUFFER_SIZE = 8,
    parameter int HASH_W         = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [HASH_W-1:0]         seed_a,
    input  logic [HASH_W-1:0]         seed_b,
    input  logic [FM_BUFFER_SIZE-1:0] index,
    input  logic                      fm_bit,
    input  logic                      finished_count,
    output logic                      busy,
    output logic [HASH_W-1:0]         sig,
    output logic                      sig_empty,
    output logic                      sig_valid
`ifdef PROJ_MINHASH_ARGMIN_EN
    ,output logic [FM_BUFFER_SIZE-1:0] sig_idx
`endif
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic [HASH_W-1:0] a_q, a_d, b_q, b_d, s1_h_q, s1_h_d, min_q, min_d, sig_q, sig_d;
    logic s1_v_q, s1_v_d, s1_bit_q, s1_bit_d, empty_q, empty_d, sig_empty_q, sig_empty_d;
    logic take, pub;
`ifdef PROJ_MINHASH_ARGMIN_EN
    logic [FM_BUFFER_SIZE-1:0] s1_idx_q, s1_idx_d, idx_q, idx_d, sig_idx_q, sig_idx_d;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (start) state_d = ACCUM;
        else if (state_q == ACCUM && finished_count) state_d = DRAIN;
        else if (state_q == DRAIN) state_d = DONE;
        else if (state_q == DONE) state_d = IDLE;
    end
    // Stage 2 compares the previous cycle's hash; strict < keeps the lowest index on ties.
    always_comb begin
        a_d         = start ? seed_a : a_q;
        b_d         = start ? seed_b : b_q;
        s1_v_d      = state_q == ACCUM && !start;
        s1_h_d      = a_q * HASH_W'(index) + b_q;
        s1_bit_d    = fm_bit;
        take        = s1_v_q && s1_bit_q && s1_h_q < min_q && (state_q == ACCUM || state_q == DRAIN);
        pub         = !start && state_q == DRAIN;
        min_d       = start ? '1 : take ? s1_h_q : min_q;
        empty_d     = start ? 1'b1 : take ? 1'b0 : empty_q;
        sig_d       = pub ? min_d : sig_q;
        sig_empty_d = pub ? empty_d : sig_empty_q;
`ifdef PROJ_MINHASH_ARGMIN_EN
        s1_idx_d    = index;
        idx_d       = start ? '0 : take ? s1_idx_q : idx_q;
        sig_idx_d   = pub ? (empty_d ? '0 : idx_d) : sig_idx_q;
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            s1_v_q      <= 1'b0;
            s1_h_q      <= '0;
            s1_bit_q    <= 1'b0;
            min_q       <= '0;
            empty_q     <= 1'b0;
            sig_q       <= '0;
            sig_empty_q <= 1'b0;
`ifdef PROJ_MINHASH_ARGMIN_EN
            s1_idx_q    <= '0;
            idx_q       <= '0;
            sig_idx_q   <= '0;
`endif
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            s1_v_q      <= s1_v_d;
            s1_h_q      <= s1_h_d;
            s1_bit_q    <= s1_bit_d;
            min_q       <= min_d;
            empty_q     <= empty_d;
            sig_q       <= sig_d;
            sig_empty_q <= sig_empty_d;
`ifdef PROJ_MINHASH_ARGMIN_EN
            s1_idx_q    <= s1_idx_d;
            idx_q       <= idx_d;
            sig_idx_q   <= sig_idx_d;
`endif
        end
    end
    always_comb begin
        busy      = state_q != IDLE;
        sig_valid = state_q == DONE;
        sig       = sig_q;
        sig_empty = sig_empty_q;
`ifdef PROJ_MINHASH_ARGMIN_EN
        sig_idx   = sig_idx_q;
`endif
    end
endmodule

// File: tb/tb_proj_minhash_accum.sv
// tb_proj_minhash_accum: directed and random passes checked against an arithmetic MinHash model.
module tb_proj_minhash_accum;
    localparam int FM = 8;
    localparam int HW = 16;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, fm_bit = 1'b0, finished_count = 1'b0;
    logic [HW-1:0] seed_a = '0, seed_b = '0;
    logic [FM-1:0] index = '0;
    logic busy, sig_empty, sig_valid;
    logic [HW-1:0] sig;
`ifdef PROJ_MINHASH_ARGMIN_EN
    logic [FM-1:0] sig_idx;
`endif
    int compared = 0, mismatched = 0, vcount = 0;
    logic [31:0] prev_sig = 0;
    proj_minhash_accum #(.FM_BUFFER_SIZE(FM), .HASH_W(HW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed_a(seed_a), .seed_b(seed_b),
        .index(index), .fm_bit(fm_bit), .finished_count(finished_count),
        .busy(busy), .sig(sig), .sig_empty(sig_empty), .sig_valid(sig_valid)
`ifdef PROJ_MINHASH_ARGMIN_EN
        , .sig_idx(sig_idx)
`endif
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (sig_valid === 1'b1) vcount <= vcount + 1;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Reference: minimum of (A*i+B) mod 65536 over set bits, first index on ties.
    task automatic model(input int unsigned a, input int unsigned b, input logic [15:0] bits, input int n,
                         output logic [31:0] m, output logic [31:0] e, output logic [31:0] ix);
        m = 32'hFFFF; e = 1; ix = 0;
        for (int i = 0; i < n; i++) begin
            int unsigned h;
            h = (a * i + b) % 32'h10000;
            if (bits[i] && (e == 1 || h < m)) begin m = h; ix = i; e = 0; end
        end
    endtask
    task automatic run_pass(input string tag, input int unsigned a, input int unsigned b,
                            input logic [15:0] bits, input int n);
        logic [31:0] m, e, ix;
        int v0;
        model(a, b, bits, n, m, e, ix);
        @(negedge clk);
        start = 1'b1; seed_a = HW'(a); seed_b = HW'(b); finished_count = 1'b0; fm_bit = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_accum"}, busy, 1);
        check({tag, "_sig_held"}, sig, prev_sig);
        v0 = vcount;
        for (int i = 0; i < n; i++) begin
            index = FM'(i); fm_bit = bits[i]; finished_count = (i == n - 1);
            @(negedge clk);
        end
        finished_count = 1'b0; fm_bit = 1'b0;
        check({tag, "_drain_valid"}, sig_valid, 0);
        check({tag, "_drain_busy"}, busy, 1);
        @(negedge clk);
        check({tag, "_done_valid"}, sig_valid, 1);
        check({tag, "_sig"}, sig, m);
        check({tag, "_empty"}, sig_empty, e);
`ifdef PROJ_MINHASH_ARGMIN_EN
        check({tag, "_idx"}, sig_idx, ix);
`endif
        @(negedge clk);
        check({tag, "_idle_valid"}, sig_valid, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_sig"}, sig, m);
        check({tag, "_pulses"}, vcount - v0, 1);
        prev_sig = m;
    endtask
    initial begin
        int v0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_sig", sig, 0);
        check("rst_empty", sig_empty, 0);
        check("rst_valid", sig_valid, 0);
        rst_n = 1'b1;
        run_pass("t1_identity", 1, 0, 16'h00FF, 8);
        run_pass("t2_two_bits", 3, 5, 16'h0044, 8);
        run_pass("t3_empty", 7, 9, 16'h0000, 8);
        run_pass("t4_wrap", 16'h8000, 16'hFFFF, 16'h0006, 8);
        run_pass("t5_tie", 0, 7, 16'h00FF, 8);
        v0 = vcount;
        @(negedge clk);
        start = 1'b1; seed_a = 16'd0; seed_b = 16'd7;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            index = FM'(i); fm_bit = 1'b1;
            @(negedge clk);
        end
        run_pass("t5_restart", 1, 0, 16'h00FF, 8);
        check("t5_single_pulse", vcount - v0, 1);
        @(negedge clk);
        start = 1'b1; seed_a = 16'd5; seed_b = 16'd9;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            index = FM'(i); fm_bit = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_busy", busy, 0);
        check("t6_sig", sig, 0);
        check("t6_empty", sig_empty, 0);
        check("t6_valid", sig_valid, 0);
`ifdef PROJ_MINHASH_ARGMIN_EN
        check("t6_idx", sig_idx, 0);
`endif
        v0 = vcount;
        for (int i = 0; i < 4; i++) begin
            index = FM'(i); fm_bit = 1'b1; finished_count = 1'b1;
            @(negedge clk);
        end
        finished_count = 1'b0; fm_bit = 1'b0;
        check("t6_no_pulse", vcount - v0, 0);
        check("t6_still_idle", busy, 0);
        prev_sig = 0;
        for (int k = 0; k < 8; k++) begin
            run_pass("rand", $urandom_range(0, 65535), $urandom_range(0, 65535),
                     16'($urandom), $urandom_range(1, 16));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
